random_event_sched: RTL and testbench
=====================================

RANDOM_EVENT_SCHED -- requirements
Module: random_event_sched

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per scheduler tick; legal values are 2 or more.
REQ-002 Parameter MIN_WAIT, default 8: minimum ticks between events; legal range 1..192.
REQ-003 clk  input  1  rising-edge system clock, the only clock.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 enable  input  1  scheduler run enable; level-sensitive.
REQ-006 rnd  input  6  pseudo-random value from the upstream random-number generator; sampled directly, no handshake.
REQ-007 event_ack  input  1  consumer acknowledge of the presented event.
REQ-008 event_valid  output  1  event presented; held high until acknowledged.
REQ-009 event_type  output  2  event code; stable while event_valid=1.
REQ-010 event_count  output  8  number of acknowledged events; saturates at 255.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, WAIT and ISSUE.
REQ-013 IDLE: if enable=1, go to LOAD on the next edge; otherwise stay in IDLE.
REQ-014 LOAD, one cycle:
- wait_cnt (8 bits) loads MIN_WAIT + rnd, zero-extended, with no overflow.
- The prescaler clears.
- The FSM goes to WAIT.
REQ-015 WAIT prescaler: counts 0..TICK_DIV-1; a tick is the cycle in which prescaler = TICK_DIV-1; the prescaler then wraps to 0.
REQ-016 WAIT decrement: wait_cnt decrements by 1 on each tick.
REQ-017 WAIT expiry: on the tick where wait_cnt = 1, all of the following happen on the same edge:
- FSM goes to ISSUE.
- event_valid goes to 1.
- event_type latches rnd[1:0] as sampled on that edge.
REQ-018 Latency: event_valid rises exactly (MIN_WAIT+rnd_load)*TICK_DIV cycles after the edge that enters WAIT, where rnd_load is rnd as sampled in LOAD.
REQ-019 WAIT abort: if enable=0 in WAIT, go to IDLE on the next edge, clearing prescaler and wait_cnt; no event is issued.
REQ-020 ISSUE hold: event_valid and event_type hold until event_ack=1 at a rising edge.
REQ-021 ISSUE acknowledge, on that edge:
- event_valid goes to 0.
- event_count increments, unless it is at 255.
- FSM goes to LOAD if enable=1, else to IDLE.
REQ-022 ISSUE ignores enable: dropping enable in ISSUE SHALL NOT withdraw a presented event.
REQ-023 event_ack outside ISSUE SHALL be ignored and SHALL NOT alter any state.
REQ-024 Back-to-back operation: after an acknowledge with enable=1, the next wait is loaded in LOAD one cycle later; events are never queued, so at most one is outstanding.
REQ-025 event_count SHALL saturate at 255 and never wrap.
REQ-026 busy SHALL equal (state != IDLE), combinationally.

Reset
REQ-027 When rst=1 at a rising edge, all of the following SHALL take effect on that edge:
- State = IDLE.
- event_valid = 0, event_type = 0, event_count = 0.
- wait_cnt = 0, prescaler = 0, busy = 0.
REQ-028 rst SHALL override enable and event_ack in every state, including mid-WAIT and mid-ISSUE.
REQ-029 Reset SHALL NOT cause a pending event to be counted.
REQ-030 After rst is released, operation SHALL resume from IDLE only.

Verification (TICK_DIV=4, MIN_WAIT=2)
REQ-031 Basic event:
- Stimulus: reset; enable=1; rnd=5 during LOAD; rnd=6'b000010 at expiry.
- Response: event_valid rises 28 cycles after WAIT entry with event_type=2; ack pulse; event_valid=0 next cycle; event_count=1.
REQ-032 Minimum wait:
- Stimulus: rnd=0 in LOAD.
- Response: event_valid rises 8 cycles after WAIT entry.
- Stimulus: rnd=63 in LOAD.
- Response: event_valid rises 260 cycles after WAIT entry; wait_cnt is 65 with no overflow.
REQ-033 Abort:
- Stimulus: enable dropped mid-WAIT (tick 3 of 7).
- Response: IDLE next cycle, busy=0, no event_valid.
- Stimulus: re-enable.
- Response: fresh LOAD.
REQ-034 Held event:
- Stimulus: event presented; no ack for 100 cycles; enable dropped; rnd changing.
- Response: event_valid and event_type stay constant.
- Stimulus: ack.
- Response: IDLE, event_count increments.
REQ-035 Spurious ack and saturation:
- Stimulus: ack held high during WAIT.
- Response: no state change.
- Stimulus: event_count forced to 255 via 255 events, then one more acknowledged event.
- Response: event_count stays 255.
REQ-036 Reset mid-operation:
- Stimulus: rst pulse in WAIT.
- Stimulus: rst pulse in ISSUE.
- Response: every output at its reset value the next cycle; event_count=0; no event completes.

Source files
------------

// File: rtl/random_event_sched_if.sv
// Event scheduler port bundle.
// The consumer side (master) drives enable, rnd and the acknowledge.
// The scheduler side (slave) presents the event and the status.
interface random_event_sched_if;
  logic       enable;
  logic [5:0] rnd;
  logic       event_ack;
  logic       event_valid;
  logic [1:0] event_type;
  logic [7:0] event_count;
  logic       busy;

  modport master (
    output enable, rnd, event_ack,
    input  event_valid, event_type, event_count, busy
  );

  modport slave (
    input  enable, rnd, event_ack,
    output event_valid, event_type, event_count, busy
  );
endinterface

// File: rtl/random_event_sched.sv
// Random event scheduler.
// In LOAD it picks a wait of MIN_WAIT + rnd ticks, where one tick is
// TICK_DIV clk cycles. When the wait expires it presents one event,
// whose type is taken from rnd on the expiry edge. The event is held
// until the consumer acknowledges it. Acknowledged events are counted,
// and the count saturates at 255.
module random_event_sched #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned MIN_WAIT = 8
) (
  input logic                 clk,
  input logic                 rst,
  random_event_sched_if.slave sched
);

  localparam int unsigned     PRE_W      = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0]      MIN_WAIT_8 = 8'(MIN_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic [PRE_W-1:0] prescaler_reg, prescaler_next;
  logic             event_valid_reg, event_valid_next;
  logic [1:0]       event_type_reg, event_type_next;
  logic [7:0]       event_count_reg, event_count_next;
  logic             tick;

  // The last prescaler cycle of each TICK_DIV-long period is the tick.
  assign tick = (prescaler_reg == PRE_LAST);

  // Next-state and datapath decisions. Every signal holds its value unless a state says otherwise.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    prescaler_next   = prescaler_reg;
    event_valid_next = event_valid_reg;
    event_type_next  = event_type_reg;
    event_count_next = event_count_reg;

    case (state_reg)
      IDLE: begin
        if (sched.enable) begin
          state_next = LOAD;
        end
      end

      LOAD: begin
        // The sum is at most 192 + 63 = 255, so it fits in 8 bits.
        wait_cnt_next  = MIN_WAIT_8 + {2'b00, sched.rnd};
        prescaler_next = '0;
        state_next     = WAIT;
      end

      WAIT: begin
        if (!sched.enable) begin
          // Abort: drop the pending wait without issuing an event.
          state_next     = IDLE;
          wait_cnt_next  = '0;
          prescaler_next = '0;
        end else if (tick) begin
          prescaler_next = '0;
          wait_cnt_next  = wait_cnt_reg - 8'd1;
          if (wait_cnt_reg == 8'd1) begin
            state_next       = ISSUE;
            event_valid_next = 1'b1;
            event_type_next  = sched.rnd[1:0];
          end
        end else begin
          prescaler_next = prescaler_reg + PRE_W'(1);
        end
      end

      ISSUE: begin
        // enable is not looked at until the acknowledge, so a presented
        // event is never withdrawn.
        if (sched.event_ack) begin
          event_valid_next = 1'b0;
          if (event_count_reg != 8'd255) begin
            event_count_next = event_count_reg + 8'd1;
          end
          state_next = sched.enable ? LOAD : IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register. Reset takes priority over every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers. Reset clears them, so a pending event is never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg    <= '0;
      prescaler_reg   <= '0;
      event_valid_reg <= 1'b0;
      event_type_reg  <= '0;
      event_count_reg <= '0;
    end else begin
      wait_cnt_reg    <= wait_cnt_next;
      prescaler_reg   <= prescaler_next;
      event_valid_reg <= event_valid_next;
      event_type_reg  <= event_type_next;
      event_count_reg <= event_count_next;
    end
  end

  assign sched.event_valid = event_valid_reg;
  assign sched.event_type  = event_type_reg;
  assign sched.event_count = event_count_reg;
  assign sched.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_random_event_sched.sv
// Self-checking bench for random_event_sched with TICK_DIV=4 and MIN_WAIT=2.
// The reference is timeline-based. Each event must appear exactly
// (MIN_WAIT + rnd_load) * TICK_DIV edges after WAIT entry, and must carry
// the rnd value driven on that edge. The expected count is a saturating
// tally of acknowledges.
module tb_random_event_sched;

  localparam int TD = 4;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  random_event_sched_if sif ();

  random_event_sched #(
    .TICK_DIV (TD),
    .MIN_WAIT (MW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sched (sif)
  );

  int vec_cnt    = 0;
  int miscompares = 0;
  int exp_count  = 0;
  int ev_num     = 0;
  int last_lat   = 0;
  logic [5:0] last_r;
  logic [1:0] last_t;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE, raise enable so that the next edge enters LOAD.
  task automatic start_from_idle();
    sif.enable    = 1'b1;
    sif.event_ack = 1'b0;
    step();
  endtask

  // Called while the DUT is in LOAD. It loads rnd=r and runs the wait.
  // It drives t on the edge where expiry is due, and random rnd on every
  // other edge. It returns once event_valid rises, or when the bound runs out.
  task automatic wait_event(input logic [5:0] r, input logic [5:0] t, input logic spurious);
    int   n;
    int   lat;
    logic got;
    logic busy_ok;
    check_val("busy_in_load", 32'(sif.busy), 32'd1);
    check_val("valid_in_load", 32'(sif.event_valid), 32'd0);
    sif.rnd       = r;
    sif.event_ack = 1'b0;
    sif.enable    = 1'b1;
    step();
    lat     = (MW + int'(r)) * TD;
    n       = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && n < lat + 20) begin
      sif.rnd       = (n == lat - 1) ? t : 6'($urandom);
      sif.event_ack = spurious ? 1'($urandom) : 1'b0;
      step();
      n++;
      if (sif.event_valid === 1'b1) got = 1'b1;
      if (sif.busy !== 1'b1) busy_ok = 1'b0;
      if (sif.event_count !== 8'(exp_count)) busy_ok = 1'b0;
    end
    sif.event_ack = 1'b0;
    check_val("event_seen", 32'(got), 32'd1);
    check_val("latency", 32'(n), 32'(lat));
    check_val("busy_count_in_wait", 32'(busy_ok), 32'd1);
    check_val("event_type", 32'(sif.event_type), 32'(t[1:0]));
    last_lat = n;
    last_r   = r;
    last_t   = t[1:0];
  endtask

  // Called while the DUT is in ISSUE. It holds off for `hold` cycles,
  // with enable and rnd wandering. Then it acknowledges, with enable set to en_after.
  task automatic ack_event(input int hold, input logic en_after);
    logic stable;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      sif.event_ack = 1'b0;
      sif.enable    = 1'($urandom);
      sif.rnd       = 6'($urandom);
      step();
      if (sif.event_valid !== 1'b1 || sif.event_type !== last_t || sif.busy !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check_val("held_stable", 32'(stable), 32'd1);
    sif.enable    = en_after;
    sif.event_ack = 1'b1;
    sif.rnd       = 6'($urandom);
    step();
    sif.event_ack = 1'b0;
    if (exp_count < 255) exp_count++;
    ev_num++;
    check_val("valid_after_ack", 32'(sif.event_valid), 32'd0);
    check_val("count_after_ack", 32'(sif.event_count), 32'(exp_count));
    check_val("busy_after_ack", 32'(sif.busy), 32'(en_after));
    $display("event %0d: rnd_load=%0d latency=%0d type=%0d hold=%0d count=%0d",
             ev_num, last_r, last_lat, last_t, hold, sif.event_count);
  endtask

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic quiet;
    rst           = 1'b1;
    sif.enable    = 1'b1;
    sif.rnd       = '0;
    sif.event_ack = 1'b1;
    step(); step(); step();
    check_val("rst_valid", 32'(sif.event_valid), 32'd0);
    check_val("rst_type", 32'(sif.event_type), 32'd0);
    check_val("rst_count", 32'(sif.event_count), 32'd0);
    check_val("rst_busy", 32'(sif.busy), 32'd0);
    rst        = 1'b0;
    sif.enable = 1'b0;

    // Ack while IDLE must change nothing.
    sif.event_ack = 1'b1;
    step(); step(); step();
    sif.event_ack = 1'b0;
    check_val("idle_ack_busy", 32'(sif.busy), 32'd0);
    check_val("idle_ack_count", 32'(sif.event_count), 32'd0);

    // Basic event: rnd 5 in LOAD gives a wait of 28 cycles, with type 2.
    start_from_idle();
    wait_event(6'd5, 6'b000010, 1'b0);
    ack_event(0, 1'b0);

    // Shortest and longest waits, run back to back.
    start_from_idle();
    wait_event(6'd0, 6'($urandom), 1'b0);
    ack_event(1, 1'b1);
    wait_event(6'd63, 6'($urandom), 1'b0);
    // Held event: 100 cycles with no ack, while enable and rnd change.
    ack_event(100, 1'b0);

    // Spurious acks throughout WAIT.
    start_from_idle();
    wait_event(6'($urandom_range(0, 7)), 6'($urandom), 1'b1);
    ack_event(2, 1'b0);

    // Abort in the third tick of a seven-tick wait, then re-enable.
    start_from_idle();
    sif.rnd = 6'd5;
    step();
    for (int i = 0; i < 2 * TD + 2; i++) step();
    sif.enable = 1'b0;
    step();
    check_val("abort_busy", 32'(sif.busy), 32'd0);
    check_val("abort_valid", 32'(sif.event_valid), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sif.rnd = 6'($urandom);
      step();
      if (sif.event_valid !== 1'b0 || sif.busy !== 1'b0) quiet = 1'b0;
    end
    check_val("abort_quiet", 32'(quiet), 32'd1);
    start_from_idle();
    wait_event(6'd5, 6'b000011, 1'b0);
    ack_event(0, 1'b0);

    // Reset in the middle of WAIT.
    start_from_idle();
    sif.rnd = 6'd10;
    step();
    for (int i = 0; i < 15; i++) step();
    rst = 1'b1;
    sif.event_ack = 1'b1;
    step();
    rst = 1'b0;
    sif.event_ack = 1'b0;
    sif.enable = 1'b0;
    exp_count = 0;
    check_val("rstw_valid", 32'(sif.event_valid), 32'd0);
    check_val("rstw_type", 32'(sif.event_type), 32'd0);
    check_val("rstw_count", 32'(sif.event_count), 32'd0);
    check_val("rstw_busy", 32'(sif.busy), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sif.event_valid !== 1'b0 || sif.busy !== 1'b0) quiet = 1'b0;
    end
    check_val("rstw_quiet", 32'(quiet), 32'd1);

    // Reset in the middle of ISSUE, with ack and enable both high: nothing is counted.
    start_from_idle();
    wait_event(6'd1, 6'b000001, 1'b0);
    rst = 1'b1;
    sif.event_ack = 1'b1;
    sif.enable = 1'b1;
    step();
    rst = 1'b0;
    sif.event_ack = 1'b0;
    sif.enable = 1'b0;
    check_val("rsti_valid", 32'(sif.event_valid), 32'd0);
    check_val("rsti_type", 32'(sif.event_type), 32'd0);
    check_val("rsti_count", 32'(sif.event_count), 32'd0);
    check_val("rsti_busy", 32'(sif.busy), 32'd0);
    step(); step();
    check_val("rsti_idle", 32'(sif.busy), 32'd0);

    // Saturation: more than 255 acknowledged events, with randomized waits, holds and acks.
    start_from_idle();
    for (int k = 0; k < 260; k++) begin
      wait_event(6'($urandom_range(0, 3)), 6'($urandom), 1'($urandom));
      ack_event(int'($urandom_range(0, 3)), (k != 259));
    end
    check_val("saturated_count", 32'(sif.event_count), 32'd255);
    check_val("final_idle", 32'(sif.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
